// File: rtl/shifter_universal.sv
// Universal shift register: logical / rotate / arithmetic shifts, either single-step
// or as a counted burst with a busy/done handshake.
module shifter_universal #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             pload,
  input  logic [WIDTH-1:0] pdatain,
  input  logic             leftright,
  input  logic [1:0]       mode,
  input  logic             serialin,
  input  logic             start,
  input  logic [CNT_W-1:0] count,
  output logic [WIDTH-1:0] pdataout,
  output logic             serialout,
  output logic             busy,
  output logic             done
);

  localparam int unsigned W = WIDTH;

  localparam logic [1:0] MODE_LOG  = 2'b00;
  localparam logic [1:0] MODE_ROT  = 2'b01;
  localparam logic [1:0] MODE_ARI  = 2'b10;
  localparam logic [1:0] MODE_HOLD = 2'b11;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [W-1:0]       data_q, data_d;
  logic               sout_q, sout_d;
  logic               done_q, done_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               dir_q, dir_d;
  logic [1:0]         mode_q, mode_d;

  logic               busy_c;
  logic               step_dir;
  logic [1:0]         step_mode;
  logic               out_bit;
  logic               fill;
  logic [W-1:0]       shifted;
  logic               real_shift;
  logic               do_step;

  assign busy_c = (state_q == ST_BURST);

  // State register and datapath flops
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      sout_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      mode_q  <= MODE_LOG;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      sout_q  <= sout_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      mode_q  <= mode_d;
    end
  end

  // Next-state: a burst runs until the last counted step or a parallel-load abort
  always_comb begin
    state_d = state_q;
    if (pload) begin
      state_d = ST_IDLE;
    end else if (state_q == ST_BURST) begin
      if (cnt_q == CNT_W'(1)) state_d = ST_IDLE;
    end else if (start && (count != '0)) begin
      state_d = ST_BURST;
    end
  end

  // One shift step; a burst uses the latched direction/mode, otherwise the live inputs
  always_comb begin
    step_dir   = busy_c ? dir_q  : leftright;
    step_mode  = busy_c ? mode_q : mode;
    out_bit    = step_dir ? data_q[W-1] : data_q[0];
    fill       = 1'b0;
    case (step_mode)
      MODE_LOG: fill = serialin;
      MODE_ROT: fill = out_bit;
      MODE_ARI: fill = step_dir ? 1'b0 : data_q[W-1];
      default:  fill = 1'b0;
    endcase
    shifted    = step_dir ? {data_q[W-2:0], fill} : {fill, data_q[W-1:1]};
    real_shift = (step_mode != MODE_HOLD);
  end

  // Outputs and datapath next values in priority order
  always_comb begin
    data_d  = data_q;
    sout_d  = sout_q;
    done_d  = 1'b0;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    mode_d  = mode_q;
    do_step = 1'b0;
    if (pload) begin
      data_d = pdatain;
      cnt_d  = '0;
    end else if (busy_c) begin
      do_step = 1'b1;
      cnt_d   = cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) done_d = 1'b1;
    end else if (start) begin
      if (count != '0) begin
        dir_d  = leftright;
        mode_d = mode;
        cnt_d  = count;
      end else begin
        done_d = 1'b1;
      end
    end else if (enable) begin
      do_step = 1'b1;
    end
    // Hold mode consumes a burst step without touching the register
    if (do_step && real_shift) begin
      data_d = shifted;
      sout_d = out_bit;
    end
  end

  assign pdataout  = data_q;
  assign serialout = sout_q;
  assign busy      = busy_c;
  assign done      = done_q;

endmodule

// File: tb/tb_shifter_universal.sv
// Bench for shifter_universal: directed scenarios plus random cycles, every cycle
// compared against an arithmetic reference model of the shift register.
module tb_shifter_universal;

  localparam int unsigned W     = 8;
  localparam int unsigned CNT_W = 4;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             enable = 1'b0;
  logic             pload = 1'b0;
  logic [W-1:0]     pdatain = '0;
  logic             leftright = 1'b0;
  logic [1:0]       mode = 2'b00;
  logic             serialin = 1'b0;
  logic             start = 1'b0;
  logic [CNT_W-1:0] count = '0;
  logic [W-1:0]     pdataout;
  logic             serialout;
  logic             busy;
  logic             done;

  shifter_universal #(.WIDTH(W), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset), .enable(enable), .pload(pload),
    .pdatain(pdatain), .leftright(leftright), .mode(mode), .serialin(serialin),
    .start(start), .count(count), .pdataout(pdataout), .serialout(serialout),
    .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  logic [W-1:0] m_q;
  logic         m_sout, m_busy, m_done, m_dir;
  logic [1:0]   m_mode;
  int           m_rem;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] shift_val(input logic [W-1:0] q, input logic left,
                                             input logic [1:0] md, input logic sin);
    logic [W-1:0] s;
    s = W'(sin);
    case (md)
      2'b00:   return left ? ((q << 1) | s) : ((q >> 1) | (s << (W-1)));
      2'b01:   return left ? ((q << 1) | (q >> (W-1))) : ((q >> 1) | (q << (W-1)));
      2'b10:   return left ? (q << 1) : W'($signed(q) >>> 1);
      default: return q;
    endcase
  endfunction

  task automatic model_shift(input logic left, input logic [1:0] md);
    if (md != 2'b11) begin
      m_sout = left ? m_q[W-1] : m_q[0];
      m_q    = shift_val(m_q, left, md, serialin);
    end
  endtask

  task automatic model_edge();
    if (!reset) begin
      m_q = '0; m_sout = 1'b0; m_busy = 1'b0; m_done = 1'b0; m_rem = 0;
      m_dir = 1'b0; m_mode = 2'b00;
      return;
    end
    m_done = 1'b0;
    if (pload) begin
      m_q = pdatain; m_busy = 1'b0; m_rem = 0;
    end else if (m_busy) begin
      model_shift(m_dir, m_mode);
      m_rem = m_rem - 1;
      if (m_rem == 0) begin
        m_busy = 1'b0; m_done = 1'b1;
      end
    end else if (start) begin
      if (count != '0) begin
        m_dir = leftright; m_mode = mode; m_rem = int'(count); m_busy = 1'b1;
      end else begin
        m_done = 1'b1;
      end
    end else if (enable) begin
      model_shift(leftright, mode);
    end
  endtask

  // One clock: model advances on the edge, outputs sampled 1 time unit later
  task automatic tick(input string tag);
    @(posedge clock);
    model_edge();
    #1;
    chk({tag, "/q"},    32'(pdataout),  32'(m_q));
    chk({tag, "/sout"}, 32'(serialout), 32'(m_sout));
    chk({tag, "/busy"}, 32'(busy),      32'(m_busy));
    chk({tag, "/done"}, 32'(done),      32'(m_done));
  endtask

  task automatic quiet();
    enable = 1'b0; pload = 1'b0; start = 1'b0;
  endtask

  task automatic do_load(input logic [W-1:0] v);
    quiet(); pload = 1'b1; pdatain = v; tick("load"); pload = 1'b0;
  endtask

  // Wait for done with a bounded cycle budget; returns cycles busy was seen
  task automatic run_burst(input string tag, input int budget, output int busy_cyc, output int done_cnt);
    busy_cyc = 0; done_cnt = 0;
    for (int i = 0; i < budget; i++) begin
      tick(tag);
      if (busy) busy_cyc++;
      if (done) begin
        done_cnt++;
        break;
      end
    end
  endtask

  int bc, dc;

  initial begin
    m_q = '0; m_sout = 1'b0; m_busy = 1'b0; m_done = 1'b0; m_rem = 0; m_dir = 1'b0; m_mode = 2'b00;

    // Reset state
    reset = 1'b0;
    tick("rst"); tick("rst");
    chk("rst_q", 32'(pdataout), 32'h0);
    reset = 1'b1;

    // Logical right, serialin=1, three single steps
    do_load(8'hA5);
    mode = 2'b00; leftright = 1'b0; serialin = 1'b1; enable = 1'b1;
    tick("lr1"); chk("lr1_val", 32'(pdataout), 32'hD2); chk("lr1_so", 32'(serialout), 32'h1);
    tick("lr2"); chk("lr2_val", 32'(pdataout), 32'hE9); chk("lr2_so", 32'(serialout), 32'h0);
    tick("lr3"); chk("lr3_val", 32'(pdataout), 32'hF4); chk("lr3_so", 32'(serialout), 32'h1);
    quiet();

    // Rotate-left burst of 4
    do_load(8'hA5);
    mode = 2'b01; leftright = 1'b1; count = 4'd4; start = 1'b1;
    tick("rot_acc"); start = 1'b0;
    chk("rot_acc_busy", 32'(busy), 32'h1);
    run_burst("rot", 10, bc, dc);
    chk("rot_busy_cyc", 32'(bc + 1), 32'd4);
    chk("rot_done_seen", 32'(dc), 32'd1);
    chk("rot_val", 32'(pdataout), 32'h5A);
    chk("rot_so", 32'(serialout), 32'h0);
    tick("rot_after"); chk("rot_done_clr", 32'(done), 32'h0);

    // Arithmetic right 3, then arithmetic left 2
    do_load(8'h96);
    mode = 2'b10; leftright = 1'b0; count = 4'd3; start = 1'b1;
    tick("ar_acc"); start = 1'b0;
    run_burst("ar", 10, bc, dc);
    chk("ar_val", 32'(pdataout), 32'hF2);
    leftright = 1'b1; count = 4'd2; start = 1'b1;
    tick("al_acc"); start = 1'b0;
    run_burst("al", 10, bc, dc);
    chk("al_val", 32'(pdataout), 32'hC8);

    // Logical-left burst aborted by pload; mid-burst control toggles ignored
    do_load(8'h01);
    mode = 2'b00; leftright = 1'b1; serialin = 1'b0; count = 4'd5; start = 1'b1;
    tick("ab_acc"); start = 1'b0;
    leftright = 1'b0; enable = 1'b1; mode = 2'b01;
    tick("ab1"); tick("ab2");
    chk("ab_pre", 32'(pdataout), 32'h04);
    enable = 1'b0; pload = 1'b1; pdatain = 8'h3C;
    tick("ab_load"); pload = 1'b0;
    chk("ab_val", 32'(pdataout), 32'h3C);
    chk("ab_busy", 32'(busy), 32'h0);
    dc = 0;
    for (int i = 0; i < 6; i++) begin
      tick("ab_idle");
      if (done) dc++;
    end
    chk("ab_no_done", 32'(dc), 32'd0);

    // Count-zero burst, then back-to-back start on the done cycle
    mode = 2'b00; count = 4'd0; start = 1'b1;
    tick("z_acc");
    chk("z_done", 32'(done), 32'h1);
    chk("z_busy", 32'(busy), 32'h0);
    chk("z_val", 32'(pdataout), 32'h3C);
    count = 4'd2;
    tick("b2b_acc"); start = 1'b0;
    chk("b2b_busy", 32'(busy), 32'h1);
    run_burst("b2b", 10, bc, dc);
    chk("b2b_done", 32'(dc), 32'd1);

    // pload and start together: pload wins
    pload = 1'b1; pdatain = 8'h5F; start = 1'b1; count = 4'd3;
    tick("ps"); quiet();
    chk("ps_busy", 32'(busy), 32'h0);

    // Reset during a 7-step burst, with start/enable asserted under reset
    mode = 2'b01; leftright = 1'b0; count = 4'd7; start = 1'b1;
    tick("r7_acc"); start = 1'b0;
    tick("r7"); tick("r7");
    reset = 1'b0; start = 1'b1; enable = 1'b1;
    tick("r7_rst");
    chk("r7_q", 32'(pdataout), 32'h0);
    chk("r7_busy", 32'(busy), 32'h0);
    chk("r7_done", 32'(done), 32'h0);
    tick("r7_rst2");
    quiet(); reset = 1'b1;
    tick("r7_rel");

    // Random traffic against the model
    for (int i = 0; i < 1500; i++) begin
      reset     = ($urandom_range(0, 99) != 0);
      pload     = ($urandom_range(0, 19) == 0);
      start     = ($urandom_range(0, 5) == 0);
      enable    = $urandom_range(0, 1) == 1;
      leftright = $urandom_range(0, 1) == 1;
      mode      = 2'($urandom_range(0, 3));
      serialin  = $urandom_range(0, 1) == 1;
      count     = CNT_W'($urandom_range(0, (1 << CNT_W) - 1));
      pdatain   = W'($urandom);
      tick("rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
